// File: rtl/risc_pipe_pkg.sv
// Encodings shared by the execute and writeback/branch stages of the pipelined core.
package risc_pipe_pkg;

    // {BS_one, BS_zero} branch-select field
    typedef enum logic [1:0] {
        BS_INC  = 2'b00,
        BS_COND = 2'b01,
        BS_JR   = 2'b10,
        BS_BR   = 2'b11
    } bs_e;

    // Register-file result select; 2'b11 is reserved and behaves like MD_F
    typedef enum logic [1:0] {
        MD_F   = 2'b00,
        MD_MEM = 2'b01,
        MD_SLT = 2'b10,
        MD_RSV = 2'b11
    } md_e;

    typedef enum logic [1:0] {
        PC_INC = 2'b00,
        PC_BRA = 2'b01,
        PC_RAA = 2'b10
    } pc_sel_e;

    // Wide enough for up to 3 squash slots
    localparam int SQ_CNT_W = 2;

endpackage

// File: rtl/wb_branch_resolve.sv
// Combinational branch resolution: taken flag, PC select and target for the latched slot.
module wb_branch_resolve
    import risc_pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              live,
    input  logic [1:0]        bs,
    input  logic              ps,
    input  logic              z,
    input  logic [DATA_W-1:0] bra,
    input  logic [DATA_W-1:0] raa,
    output logic              taken,
    output logic [1:0]        pc_sel,
    output logic [DATA_W-1:0] pc_target
);

    always_comb begin
        taken     = 1'b0;
        pc_sel    = PC_INC;
        pc_target = '0;
        // An annulled slot never redirects fetch, whatever its branch bits say
        if (live) begin
            case (bs_e'(bs))
                BS_COND: begin
                    if (ps ? z : ~z) begin
                        taken     = 1'b1;
                        pc_sel    = PC_BRA;
                        pc_target = bra;
                    end
                end
                BS_JR: begin
                    taken     = 1'b1;
                    pc_sel    = PC_RAA;
                    pc_target = raa;
                end
                BS_BR: begin
                    taken     = 1'b1;
                    pc_sel    = PC_BRA;
                    pc_target = bra;
                end
                default: begin
                    taken     = 1'b0;
                    pc_sel    = PC_INC;
                    pc_target = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/wb_branch_stage.sv
// Writeback and branch-resolution stage: falling-edge pipeline latch, result mux,
// branch squash counter and retired/squashed instruction counters.
module wb_branch_stage
    import risc_pipe_pkg::*;
#(
    parameter int SQUASH_SLOTS = 2,
    parameter int DATA_W       = 32
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              RW,
    input  logic [4:0]        DA,
    input  logic [1:0]        MD,
    input  logic              BS_one,
    input  logic              BS_zero,
    input  logic              PS,
    input  logic              Z,
    input  logic              VxorN,
    input  logic [DATA_W-1:0] F,
    input  logic [DATA_W-1:0] Data_Out,
    input  logic [DATA_W-1:0] BrA,
    input  logic [DATA_W-1:0] RAA,
    output logic              WR_EN,
    output logic [4:0]        WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic [1:0]        PC_SEL,
    output logic [DATA_W-1:0] PC_TARGET,
    output logic              FLUSH,
    output logic [31:0]       RETIRED_CNT,
    output logic [31:0]       SQUASHED_CNT
);

    logic              rw_q;
    logic [4:0]        da_q;
    logic [1:0]        md_q;
    logic [1:0]        bs_q;
    logic              ps_q;
    logic              z_q;
    logic              vxorn_q;
    logic [DATA_W-1:0] f_q;
    logic [DATA_W-1:0] dout_q;
    logic [DATA_W-1:0] bra_q;
    logic [DATA_W-1:0] raa_q;
    logic              live_q;

    logic [SQ_CNT_W-1:0] sq_cnt;
    logic [SQ_CNT_W-1:0] sq_eff;
    logic [SQ_CNT_W-1:0] sq_cnt_nxt;
    logic                capture_live;
    logic                taken;
    logic [1:0]          pc_sel;
    logic [DATA_W-1:0]   pc_target;
    logic [31:0]         retired_q;
    logic [31:0]         squashed_q;

    wb_branch_resolve #(.DATA_W(DATA_W)) u_resolve (
        .live      (live_q),
        .bs        (bs_q),
        .ps        (ps_q),
        .z         (z_q),
        .bra       (bra_q),
        .raa       (raa_q),
        .taken     (taken),
        .pc_sel    (pc_sel),
        .pc_target (pc_target)
    );

    // A taken branch in the held slot loads the counter at this very edge, so the
    // instruction captured now is already the first annulled one.
    always_comb begin
        sq_eff       = taken ? SQ_CNT_W'(SQUASH_SLOTS) : sq_cnt;
        capture_live = (sq_eff == '0);
        sq_cnt_nxt   = capture_live ? '0 : sq_eff - 1'b1;
    end

    always_ff @(negedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            rw_q       <= 1'b0;
            da_q       <= '0;
            md_q       <= MD_F;
            bs_q       <= BS_INC;
            ps_q       <= 1'b0;
            z_q        <= 1'b0;
            vxorn_q    <= 1'b0;
            f_q        <= '0;
            dout_q     <= '0;
            bra_q      <= '0;
            raa_q      <= '0;
            live_q     <= 1'b1;
            sq_cnt     <= '0;
            retired_q  <= '0;
            squashed_q <= '0;
        end else begin
            rw_q    <= RW;
            da_q    <= DA;
            md_q    <= MD;
            bs_q    <= {BS_one, BS_zero};
            ps_q    <= PS;
            z_q     <= Z;
            vxorn_q <= VxorN;
            f_q     <= F;
            dout_q  <= Data_Out;
            bra_q   <= BrA;
            raa_q   <= RAA;
            live_q  <= capture_live;
            sq_cnt  <= sq_cnt_nxt;
            if (capture_live) begin
                retired_q <= retired_q + 32'd1;
            end else begin
                squashed_q <= squashed_q + 32'd1;
            end
        end
    end

    always_comb begin
        WR_DATA = f_q;
        case (md_e'(md_q))
            MD_MEM:  WR_DATA = dout_q;
            MD_SLT:  WR_DATA = {{(DATA_W-1){1'b0}}, vxorn_q};
            default: WR_DATA = f_q;
        endcase
    end

    // R0 is hardwired to zero, so a write to it is suppressed
    assign WR_EN        = rw_q & live_q & (da_q != 5'd0);
    assign WR_ADDR      = da_q;
    assign PC_SEL       = pc_sel;
    assign PC_TARGET    = pc_target;
    assign FLUSH        = taken;
    assign RETIRED_CNT  = retired_q;
    assign SQUASHED_CNT = squashed_q;

endmodule

// File: tb/tb_wb_branch_stage.sv
// Bench for wb_branch_stage: driver pushes model expectations, a monitor pops and compares.
module tb_wb_branch_stage;

    localparam int SQUASH_SLOTS = 2;
    localparam int DATA_W       = 32;

    logic              CLOCK;
    logic              RESET;
    logic              RW;
    logic [4:0]        DA;
    logic [1:0]        MD;
    logic              BS_one;
    logic              BS_zero;
    logic              PS;
    logic              Z;
    logic              VxorN;
    logic [DATA_W-1:0] F;
    logic [DATA_W-1:0] Data_Out;
    logic [DATA_W-1:0] BrA;
    logic [DATA_W-1:0] RAA;
    logic              WR_EN;
    logic [4:0]        WR_ADDR;
    logic [DATA_W-1:0] WR_DATA;
    logic [1:0]        PC_SEL;
    logic [DATA_W-1:0] PC_TARGET;
    logic              FLUSH;
    logic [31:0]       RETIRED_CNT;
    logic [31:0]       SQUASHED_CNT;

    typedef struct packed {
        logic        rw;
        logic [4:0]  da;
        logic [1:0]  md;
        logic [1:0]  bs;
        logic        ps;
        logic        z;
        logic        vxorn;
        logic [31:0] f;
        logic [31:0] dout;
        logic [31:0] bra;
        logic [31:0] raa;
    } instr_t;

    typedef struct packed {
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [31:0] wr_data;
        logic [1:0]  pc_sel;
        logic [31:0] pc_target;
        logic        flush;
        logic [31:0] retired;
        logic [31:0] squashed;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: slots still to be annulled, and instruction tallies
    int          m_skip;
    logic [31:0] m_ret;
    logic [31:0] m_sq;

    wb_branch_stage #(.SQUASH_SLOTS(SQUASH_SLOTS), .DATA_W(DATA_W)) dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .RW           (RW),
        .DA           (DA),
        .MD           (MD),
        .BS_one       (BS_one),
        .BS_zero      (BS_zero),
        .PS           (PS),
        .Z            (Z),
        .VxorN        (VxorN),
        .F            (F),
        .Data_Out     (Data_Out),
        .BrA          (BrA),
        .RAA          (RAA),
        .WR_EN        (WR_EN),
        .WR_ADDR      (WR_ADDR),
        .WR_DATA      (WR_DATA),
        .PC_SEL       (PC_SEL),
        .PC_TARGET    (PC_TARGET),
        .FLUSH        (FLUSH),
        .RETIRED_CNT  (RETIRED_CNT),
        .SQUASHED_CNT (SQUASHED_CNT)
    );

    // Clock / reset
    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    function automatic instr_t mk(input logic rw, input logic [4:0] da, input logic [1:0] md,
                                  input logic [1:0] bs, input logic ps, input logic z,
                                  input logic vx, input logic [31:0] f, input logic [31:0] dout,
                                  input logic [31:0] bra, input logic [31:0] raa);
        instr_t i;
        i.rw = rw; i.da = da; i.md = md; i.bs = bs; i.ps = ps; i.z = z; i.vxorn = vx;
        i.f = f; i.dout = dout; i.bra = bra; i.raa = raa;
        return i;
    endfunction

    // Reference model: what the stage must show while this instruction is held
    task automatic model_issue(input instr_t i);
        exp_t e;
        logic tk;
        e = '0;
        tk = 1'b0;
        e.wr_addr = i.da;
        if (i.md == 2'd1)      e.wr_data = i.dout;
        else if (i.md == 2'd2) e.wr_data = {31'd0, i.vxorn};
        else                   e.wr_data = i.f;
        if (m_skip > 0) begin
            m_skip = m_skip - 1;
            m_sq   = m_sq + 1;
        end else begin
            m_ret    = m_ret + 1;
            e.wr_en  = i.rw && (i.da != 5'd0);
            if (i.bs == 2'd1 && (i.ps ? i.z : !i.z)) begin
                tk = 1'b1; e.pc_sel = 2'd1; e.pc_target = i.bra;
            end else if (i.bs == 2'd2) begin
                tk = 1'b1; e.pc_sel = 2'd2; e.pc_target = i.raa;
            end else if (i.bs == 2'd3) begin
                tk = 1'b1; e.pc_sel = 2'd1; e.pc_target = i.bra;
            end
            if (tk) begin
                e.flush = 1'b1;
                m_skip  = SQUASH_SLOTS;
            end
        end
        e.retired  = m_ret;
        e.squashed = m_sq;
        exp_q.push_back(e);
    endtask

    // Driver: present one instruction for capture at the next falling edge
    task automatic issue(input instr_t i);
        @(posedge CLOCK);
        #1;
        RW = i.rw; DA = i.da; MD = i.md; BS_one = i.bs[1]; BS_zero = i.bs[0];
        PS = i.ps; Z = i.z; VxorN = i.vxorn; F = i.f; Data_Out = i.dout;
        BrA = i.bra; RAA = i.raa;
        model_issue(i);
    endtask

    task automatic model_reset();
        m_skip = 0;
        m_ret  = '0;
        m_sq   = '0;
        exp_q.push_back('0);
    endtask

    // Asynchronous reset pulse spanning one falling edge, released before the next rising edge
    task automatic do_reset();
        @(posedge CLOCK);
        #1;
        RESET = 1'b0;
        model_reset();
        @(negedge CLOCK);
        #2;
        RESET = 1'b1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: outputs are stable from the falling edge, sampled at the rising edge
    initial begin
        forever begin
            @(posedge CLOCK);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_en",        {31'd0, WR_EN},  {31'd0, mon_e.wr_en});
                check("wr_addr",      {27'd0, WR_ADDR}, {27'd0, mon_e.wr_addr});
                check("wr_data",      WR_DATA,         mon_e.wr_data);
                check("pc_sel",       {30'd0, PC_SEL}, {30'd0, mon_e.pc_sel});
                check("pc_target",    PC_TARGET,       mon_e.pc_target);
                check("flush",        {31'd0, FLUSH},  {31'd0, mon_e.flush});
                check("retired_cnt",  RETIRED_CNT,     mon_e.retired);
                check("squashed_cnt", SQUASHED_CNT,    mon_e.squashed);
            end
        end
    end

    initial begin
        instr_t r;
        RESET = 1'b0;
        RW = 1'b0; DA = '0; MD = '0; BS_one = 1'b0; BS_zero = 1'b0;
        PS = 1'b0; Z = 1'b0; VxorN = 1'b0; F = '0; Data_Out = '0; BrA = '0; RAA = '0;
        model_reset();
        repeat (2) @(negedge CLOCK);
        #2;
        RESET = 1'b1;

        // Result mux and R0 suppression
        issue(mk(1'b1, 5'd5, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h0, 32'h0));
        issue(mk(1'b1, 5'd6, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 32'h5, 32'hDEADBEEF, 32'h0, 32'h0));
        issue(mk(1'b1, 5'd6, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1, 32'h5, 32'hDEADBEEF, 32'h0, 32'h0));
        issue(mk(1'b1, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 32'h0, 32'h0));
        issue(mk(1'b1, 5'd8, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1, 32'hCAFE, 32'h1, 32'h0, 32'h0));
        // Conditional taken, two annulled slots, third writes
        issue(mk(1'b1, 5'd9, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 32'h9, 32'h0, 32'h40, 32'h0));
        issue(mk(1'b1, 5'd3, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 32'h11, 32'h0, 32'h99, 32'h0));
        issue(mk(1'b1, 5'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h22, 32'h0, 32'h0, 32'h0));
        issue(mk(1'b1, 5'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h33, 32'h0, 32'h0, 32'h0));
        // Not-taken conditional, then register jump
        issue(mk(1'b1, 5'd4, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 32'h40, 32'h0));
        issue(mk(1'b0, 5'd4, 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h80));
        issue(mk(1'b1, 5'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0, 32'h0, 32'h0));
        issue(mk(1'b1, 5'd1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h2, 32'h0, 32'h0, 32'h0));
        // Back-to-back unconditional branches
        issue(mk(1'b1, 5'd2, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 32'h100, 32'h0));
        issue(mk(1'b1, 5'd2, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 32'h200, 32'h0, 32'h200, 32'h0));
        issue(mk(1'b1, 5'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 32'h0));
        issue(mk(1'b1, 5'd2, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 32'h0));
        // Reset while a squash is pending
        issue(mk(1'b1, 5'd1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0, 32'h44, 32'h0));
        do_reset();
        issue(mk(1'b1, 5'd7, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 32'h77, 32'h0, 32'h0, 32'h0));

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                do_reset();
            end else begin
                r.rw    = 1'($urandom_range(0, 1));
                r.da    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                r.md    = 2'($urandom_range(0, 3));
                r.bs    = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
                r.ps    = 1'($urandom_range(0, 1));
                r.z     = 1'($urandom_range(0, 1));
                r.vxorn = 1'($urandom_range(0, 1));
                r.f     = $urandom;
                r.dout  = $urandom;
                r.bra   = $urandom;
                r.raa   = $urandom;
                issue(r);
            end
        end

        repeat (2) @(posedge CLOCK);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
